modificacion_ciclo_multicanal: RTL and testbench

Parametrised, multi-channel successor of the single-channel duty-cycle modifier. Generates N_CH independent PWM outputs from one 100 MHz clock: an internal prescaler replaces the separate working clock. Per-channel duty is stepped by up/down buttons routed through a channel selector. Duty changes take effect only at period boundaries, so outputs never glitch. The block sits between the debounced button inputs and the PWM pins.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/edge_sync_det.sv | 28 ++
 rtl/modificacion_ciclo_multicanal.sv | 107 ++++++++++
 tb/tb_modificacion_ciclo_multicanal.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM helpers: limit-mode encoding and the single-step duty update.
package pwm_pkg;

  localparam logic LIM_SAT  = 1'b0;
  localparam logic LIM_WRAP = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // One step of a duty value bounded to 0..max, saturating or wrapping at the ends.
  function automatic int unsigned duty_step(input int unsigned value, input logic dir,
                                            input logic mode, input int unsigned max);
    int unsigned res;
    if (dir == DIR_UP) begin
      if (value >= max) res = (mode == LIM_WRAP) ? 0 : max;
      else              res = value + 1;
    end else begin
      if (value == 0) res = (mode == LIM_WRAP) ? max : 0;
      else            res = value - 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Two-flop synchroniser followed by a history flop; pulses for one cycle on a rising edge.
module edge_sync_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic [1:0] sync_q, sync_d;
  logic       hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[0], d_i};
    hist_d = sync_q[1];
    edge_o = sync_q[1] & ~hist_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/modificacion_ciclo_multicanal.sv
// Multi-channel PWM generator with button-stepped duty; duty changes latch at period wrap.
module modificacion_ciclo_multicanal
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned DUTY_W   = 4,
  parameter int unsigned PRESCALE = 6,
  parameter int unsigned DUTY_RST = 8
) (
  input  logic                                   clk_100MHz,
  input  logic                                   rst,
  input  logic                                   up,
  input  logic                                   down,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_select,
  input  logic                                   chip_select,
  input  logic                                   func_select,
  output logic [N_CH-1:0]                        signal_out,
  output logic [DUTY_W-1:0]                      ciclo_actual,
  output logic                                   period_start
);

  localparam int unsigned MAX = (1 << DUTY_W) - 1;
  localparam int unsigned CSW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic up_edge, down_edge;

  edge_sync_det u_up_det (
    .clk_i  (clk_100MHz),
    .rst_ni (rst),
    .d_i    (up),
    .edge_o (up_edge)
  );

  edge_sync_det u_down_det (
    .clk_i  (clk_100MHz),
    .rst_ni (rst),
    .d_i    (down),
    .edge_o (down_edge)
  );

  logic [PSW-1:0]    presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] dp_q [N_CH];
  logic [DUTY_W-1:0] dp_d [N_CH];
  logic [DUTY_W-1:0] da_q [N_CH];
  logic [DUTY_W-1:0] da_d [N_CH];
  logic [N_CH-1:0]   sig_q, sig_d;

  logic tick, cnt_last, wrap, sel_valid, step_en;

  // Prescaler and period counter
  always_comb begin
    tick     = (presc_q == PSW'(PRESCALE - 1));
    cnt_last = (cnt_q == DUTY_W'(MAX - 1));
    wrap     = tick & cnt_last;
    presc_d  = tick ? '0 : presc_q + PSW'(1);
    cnt_d    = cnt_q;
    if (tick) cnt_d = cnt_last ? '0 : cnt_q + DUTY_W'(1);
  end

  // Simultaneous up and down edges cancel out.
  always_comb begin
    sel_valid = ({1'b0, ch_select} < (CSW + 1)'(N_CH));
    step_en   = chip_select & sel_valid & (up_edge ^ down_edge);
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      dp_d[i] = dp_q[i];
      if (step_en && (ch_select == CSW'(i))) begin
        dp_d[i] = DUTY_W'(duty_step(32'(dp_q[i]), up_edge, func_select, MAX));
      end
      da_d[i]  = wrap ? dp_q[i] : da_q[i];
      sig_d[i] = (cnt_q < da_q[i]);
    end
  end

  always_comb begin
    ciclo_actual = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_valid && (ch_select == CSW'(i))) ciclo_actual = dp_q[i];
    end
  end

  assign signal_out   = sig_q;
  assign period_start = wrap;

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        dp_q[i] <= DUTY_W'(DUTY_RST);
        da_q[i] <= DUTY_W'(DUTY_RST);
      end
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      dp_q    <= dp_d;
      da_q    <= da_d;
    end
  end

endmodule

// File: tb/tb_modificacion_ciclo_multicanal.sv
// Directed bench for the multi-channel PWM, PRESCALE = 1 so a period is 15 clocks.
module tb_modificacion_ciclo_multicanal;

  logic       clk_100MHz = 1'b0;
  logic       rst;
  logic       up, down, chip_select, func_select;
  logic [0:0] ch_select;
  logic [1:0] signal_out;
  logic [3:0] ciclo_actual;
  logic       period_start;

  int total_cnt = 0;
  int pass_cnt  = 0;

  modificacion_ciclo_multicanal #(
    .N_CH     (2),
    .DUTY_W   (4),
    .PRESCALE (1),
    .DUTY_RST (8)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .up           (up),
    .down         (down),
    .ch_select    (ch_select),
    .chip_select  (chip_select),
    .func_select  (func_select),
    .signal_out   (signal_out),
    .ciclo_actual (ciclo_actual),
    .period_start (period_start)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic step(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic press_up();
    up = 1'b1; step(4); up = 1'b0; step(4);
  endtask

  task automatic press_down();
    down = 1'b1; step(4); down = 1'b0; step(4);
  endtask

  task automatic wait_ps(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (period_start === 1'b1) break;
      step(1);
    end
    chk(tag, int'(period_start), 1);
  endtask

  // Checks one full period sample by sample: sample j holds (j-2) < duty.
  task automatic check_period(input string tag, input int e0, input int e1, input bit inj);
    int m0, m1, ps;
    m0 = 0; m1 = 0; ps = 0;
    wait_ps({tag, "_sync"});
    step(1);
    for (int j = 2; j <= 16; j++) begin
      step(1);
      if (signal_out[0] !== ((j - 2) < e0)) m0++;
      if (signal_out[1] !== ((j - 2) < e1)) m1++;
      if (period_start === 1'b1) ps++;
      if (inj && j == 3) down = 1'b1;
      if (inj && j == 8) down = 1'b0;
    end
    chk({tag, "_ch0_bad_samples"}, m0, 0);
    chk({tag, "_ch1_bad_samples"}, m1, 0);
    chk({tag, "_period_start_count"}, ps, 1);
  endtask

  initial begin
    int first_ps;
    rst = 1'b1; up = 1'b0; down = 1'b0;
    chip_select = 1'b1; func_select = 1'b0; ch_select = 1'b0;
    #3 rst = 1'b0;
    step(3);
    chk("rst_signal_out", int'(signal_out), 0);
    chk("rst_ciclo", int'(ciclo_actual), 8);
    chk("rst_period_start", int'(period_start), 0);

    rst = 1'b1;
    first_ps = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (period_start === 1'b1) begin first_ps = k; break; end
    end
    chk("first_period_start", first_ps, 14);
    check_period("reset_duty", 8, 8, 1'b0);

    ch_select = 1'b1;
    repeat (3) press_up();
    chk("ch1_ciclo_11", int'(ciclo_actual), 11);
    ch_select = 1'b0;
    step(1);
    chk("ch0_ciclo_8", int'(ciclo_actual), 8);
    check_period("ch1_11", 8, 11, 1'b0);

    repeat (20) press_up();
    chk("sat_ciclo_15", int'(ciclo_actual), 15);
    check_period("sat_high", 15, 11, 1'b0);

    func_select = 1'b1;
    press_up();
    chk("wrap_up_0", int'(ciclo_actual), 0);
    check_period("wrap_low", 0, 11, 1'b0);

    up = 1'b1; down = 1'b1; step(4);
    up = 1'b0; down = 1'b0; step(4);
    chk("simul_no_change", int'(ciclo_actual), 0);

    chip_select = 1'b0;
    press_up();
    chk("chip_sel_off", int'(ciclo_actual), 0);
    chip_select = 1'b1;

    func_select = 1'b0;
    press_down();
    chk("sat_down_0", int'(ciclo_actual), 0);
    func_select = 1'b1;
    press_down();
    chk("wrap_down_15", int'(ciclo_actual), 15);

    check_period("midperiod", 15, 11, 1'b1);
    chk("mid_ciclo_14", int'(ciclo_actual), 14);
    check_period("after_mid", 14, 11, 1'b0);

    repeat (5) press_up();
    chk("ch0_ciclo_3", int'(ciclo_actual), 3);
    ch_select = 1'b1;
    repeat (8) press_down();
    chk("ch1_ciclo_3", int'(ciclo_actual), 3);
    check_period("duty3", 3, 3, 1'b0);

    wait_ps("pre_reset_sync");
    step(2);
    chk("pre_reset_high", int'(signal_out), 3);
    rst = 1'b0;
    #1;
    chk("async_reset_out", int'(signal_out), 0);
    chk("async_reset_ciclo", int'(ciclo_actual), 8);
    step(2);
    rst = 1'b1;
    first_ps = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (period_start === 1'b1) begin first_ps = k; break; end
    end
    chk("restart_period_start", first_ps, 14);
    check_period("post_reset", 8, 8, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
